// File: rtl/fft_frame_sched.sv
// fft_frame_sched: stream-side scheduler for a pipelined, clock-enabled FFT core.
// It turns a valid/ready sample stream into core CE pulses, throttles the core
// when downstream stalls, and frames the core's results with first/last markers.
// On a flush it pads the partial frame with zeros and drains the pipeline,
// without presenting zero-only frames.
//
// Ports:
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   i_enable, i_flush         leave IDLE / finish current frame and drain
//   i_valid, o_ready, i_data  input sample stream {real, imag}
//   o_fft_reset, o_fft_ce,    core reset (active high), clock enable, sample
//   o_fft_sample
//   i_fft_result, i_fft_sync  core result and frame sync
//   o_valid, i_ready, o_data  output stream (o_data passes i_fft_result through)
//   o_first, o_last           output index 0 / N-1 markers
//   o_busy, o_err             not idle / sticky framing error
module fft_frame_sched #(
  parameter int unsigned IWIDTH  = 16,
  parameter int unsigned OWIDTH  = 22,
  parameter int unsigned LGWIDTH = 11,
  parameter int unsigned PFW     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [2*IWIDTH-1:0]   i_data,
  output logic                  o_fft_reset,
  output logic                  o_fft_ce,
  output logic [2*IWIDTH-1:0]   o_fft_sample,
  input  logic [2*OWIDTH-1:0]   i_fft_result,
  input  logic                  i_fft_sync,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2*OWIDTH-1:0]   o_data,
  output logic                  o_first,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAD   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [LGWIDTH-1:0] IDX_LAST = '1;
  localparam logic [PFW-1:0]     PEND_MAX = '1;

  logic [1:0]          r_state;
  logic [LGWIDTH-1:0]  r_in_cnt;
  logic [LGWIDTH-1:0]  r_out_cnt;
  logic [PFW-1:0]      r_pend;
  logic                r_primed;
  logic                r_out_pend;
  logic                r_err;

  logic [1:0]          w_state_nxt;
  logic                w_slot;
  logic                w_valid;
  logic                w_out_hs;
  logic                w_last_hs;
  logic                w_ready;
  logic                w_ce;
  logic [2*IWIDTH-1:0] w_sample;
  logic                w_wrap;

  // Next state, handshakes and core drive
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_ce        = 1'b0;
    w_sample    = '0;
    // The core holds its result while CE is low, so a pending result only
    // blocks new CEs until downstream takes it.
    w_slot      = !r_out_pend || i_ready;
    w_valid     = r_out_pend && (r_primed || i_fft_sync) && (r_pend != '0);
    w_out_hs    = w_valid && i_ready;
    w_last_hs   = w_out_hs && (r_out_cnt == IDX_LAST);
    case (r_state)
      S_IDLE: begin
        if (i_enable) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_sample = i_data;
        if (i_flush) begin
          if (r_in_cnt != '0)    w_state_nxt = S_PAD;
          else if (r_pend != '0) w_state_nxt = S_DRAIN;
          else                   w_state_nxt = S_IDLE;
        end else begin
          w_ready = w_slot;
          w_ce    = i_valid && w_slot;
        end
      end
      S_PAD: begin
        w_ce = w_slot;
        if (w_ce && (r_in_cnt == IDX_LAST)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_ce = w_slot;
        if ((r_pend == '0) || (w_last_hs && (r_pend == PFW'(1)))) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Only RUN/PAD wraps close a real frame; DRAIN feeds filler
    w_wrap = w_ce && (r_in_cnt == IDX_LAST) && ((r_state == S_RUN) || (r_state == S_PAD));
  end

  // State, counters and output tracking
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_pend     <= '0;
      r_primed   <= 1'b0;
      r_out_pend <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        // Core is held in reset here, so any priming is lost
        r_in_cnt   <= '0;
        r_out_cnt  <= '0;
        r_pend     <= '0;
        r_primed   <= 1'b0;
        r_out_pend <= 1'b0;
      end else begin
        if (w_ce && ((r_state == S_RUN) || (r_state == S_PAD))) r_in_cnt <= r_in_cnt + 1'b1;
        if (w_out_hs) r_out_cnt <= r_out_cnt + 1'b1;

        if (w_wrap && !w_last_hs) begin
          if (r_pend == PEND_MAX) r_err <= 1'b1;
          else                    r_pend <= r_pend + 1'b1;
        end else if (w_last_hs && !w_wrap) begin
          r_pend <= r_pend - 1'b1;
        end

        // Results seen before the first sync are pipeline garbage
        if (w_ce)                                                 r_out_pend <= 1'b1;
        else if (w_out_hs || (r_out_pend && !r_primed && !i_fft_sync)) r_out_pend <= 1'b0;

        if (r_out_pend && i_fft_sync) r_primed <= 1'b1;
        if (i_fft_sync && r_out_pend && r_primed && (r_out_cnt != '0)) r_err <= 1'b1;
      end
    end
  end

  assign o_ready      = w_ready;
  assign o_fft_ce     = w_ce;
  assign o_fft_sample = w_sample;
  assign o_fft_reset  = (r_state == S_IDLE);
  assign o_valid      = w_valid;
  assign o_data       = i_fft_result;
  assign o_first      = w_valid && (r_out_cnt == '0);
  assign o_last       = w_valid && (r_out_cnt == IDX_LAST);
  assign o_busy       = (r_state != S_IDLE);
  assign o_err        = r_err;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched: a CE-driven core model (fixed latency, sync on
// each frame's first result) plus a frame-level scoreboard of expected outputs.
module tb_fft_frame_sched;

  localparam int unsigned IW  = 16;
  localparam int unsigned OW  = 22;
  localparam int unsigned LG  = 6;
  localparam int unsigned N   = 1 << LG;
  localparam int unsigned PFW = 4;
  localparam int unsigned LAT = N + 3;

  logic clk;
  logic rst_n, en, fl, vin, rdy;
  logic [2*IW-1:0] din;
  logic o_ready, o_fft_reset, o_fft_ce, o_valid, o_first, o_last, o_busy, o_err;
  logic [2*IW-1:0] o_fft_sample;
  logic [2*OW-1:0] core_res, o_data;
  logic core_sync_r, force_sync, fft_sync;

  assign fft_sync = core_sync_r | force_sync;

  fft_frame_sched #(.IWIDTH(IW), .OWIDTH(OW), .LGWIDTH(LG), .PFW(PFW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_flush(fl),
    .i_valid(vin), .o_ready(o_ready), .i_data(din),
    .o_fft_reset(o_fft_reset), .o_fft_ce(o_fft_ce), .o_fft_sample(o_fft_sample),
    .i_fft_result(core_res), .i_fft_sync(fft_sync),
    .o_valid(o_valid), .i_ready(rdy), .o_data(o_data),
    .o_first(o_first), .o_last(o_last), .o_busy(o_busy), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*OW-1:0] xf(input logic [2*IW-1:0] s);
    logic signed [IW-1:0] re, im;
    re = s[2*IW-1:IW];
    im = s[IW-1:0];
    return {OW'(re), OW'(im)};
  endfunction

  // Core model: result of sample k appears on the CE LAT samples later
  logic [2*IW-1:0] core_q[$];
  int core_idx;
  always @(posedge clk) begin
    if (o_fft_reset === 1'b1) begin
      core_q.delete();
      core_idx    <= 0;
      core_res    <= '0;
      core_sync_r <= 1'b0;
    end else if (o_fft_ce === 1'b1) begin
      core_q.push_back(o_fft_sample);
      if (core_q.size() > LAT) begin
        core_res    <= xf(core_q[0]);
        core_sync_r <= ((core_idx % N) == 0);
        core_idx    <= core_idx + 1;
        void'(core_q.pop_front());
      end else begin
        core_res    <= (2*OW)'({$urandom, $urandom});
        core_sync_r <= 1'b0;
      end
    end
  end

  logic [2*OW-1:0] exp_q[$];
  logic [2*OW-1:0] part_q[$];
  int n_checks, n_fail, out_n, acc_n;
  logic err_exp, chk_ce;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic close_frame();
    while (part_q.size() > 0) exp_q.push_back(part_q.pop_front());
  endtask

  // Called at negedge with inputs set; evaluates then advances one cycle
  task automatic step();
    logic [2*OW-1:0] e;
    #1;
    if (vin && o_ready) begin
      part_q.push_back(xf(din));
      acc_n++;
      if (part_q.size() == N) close_frame();
    end
    if (o_valid && !force_sync) chk("first_vs_sync", o_first, fft_sync);
    if (o_valid && rdy) begin
      chk("output_expected", 64'(exp_q.size() == 0), 0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_data", o_data, e);
        chk("out_first", o_first, 64'((out_n % N) == 0));
        chk("out_last", o_last, 64'((out_n % N) == N - 1));
        out_n++;
      end
    end
    chk("ce_under_backpressure", o_fft_ce && o_valid && !rdy, 0);
    if (chk_ce) chk("ce_stream", o_fft_ce, 1);
    chk("err", o_err, err_exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_run();
    out_n = 0;
    acc_n = 0;
    en = 1'b1;
    step();
    en = 1'b0;
    chk("busy_after_enable", o_busy, 1);
  endtask

  task automatic flush_and_drain(input string tag, input int exp_outs, input bit rand_rdy);
    int c;
    if (part_q.size() != 0) begin
      while (part_q.size() < N) part_q.push_back('0);
      close_frame();
    end
    vin = 1'b0;
    fl  = 1'b1;
    step();
    fl = 1'b0;
    c = 0;
    while (o_busy && c < 5000) begin
      rdy = rand_rdy ? 1'($urandom) : 1'b1;
      step();
      c++;
    end
    chk({tag, "_idle"}, o_busy, 0);
    chk({tag, "_fft_reset"}, o_fft_reset, 1);
    chk({tag, "_left_over"}, 64'(exp_q.size() + part_q.size()), 0);
    chk({tag, "_count"}, 64'(out_n), 64'(exp_outs));
    rdy = 1'b1;
    repeat (8) begin
      step();
      chk({tag, "_no_extra"}, o_valid, 0);
    end
  endtask

  initial begin
    int c;
    n_checks = 0; n_fail = 0; out_n = 0; acc_n = 0;
    err_exp = 1'b0; chk_ce = 1'b0; force_sync = 1'b0;
    rst_n = 1'b0; en = 1'b0; fl = 1'b0; vin = 1'b0; rdy = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    chk("rst_fft_reset", o_fft_reset, 1);
    chk("rst_ce", o_fft_ce, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    rst_n = 1'b1;
    step();

    // Three frames of impulses at full rate, then an aligned flush (two frames pending)
    start_run();
    rdy = 1'b1;
    chk_ce = 1'b1;
    for (int i = 0; i < 3 * N; i++) begin
      vin = 1'b1;
      din = ((i % N) == 0) ? 32'h7FFF_0000 : 32'h0;
      step();
    end
    chk_ce = 1'b0;
    chk("t2_fed", 64'(acc_n), 64'(3 * N));
    flush_and_drain("t2", 3 * N, 1'b0);

    // Same impulses with random valid and 50% downstream ready
    start_run();
    c = 0;
    while (acc_n < 3 * N && c < 5000) begin
      vin = ($urandom_range(3) != 0);
      din = ((acc_n % N) == 0) ? 32'h7FFF_0000 : 32'h0;
      rdy = 1'($urandom);
      step();
      c++;
    end
    chk("t3_fed", 64'(acc_n), 64'(3 * N));
    flush_and_drain("t3", 3 * N, 1'b1);

    // 1.5 frames of random data, then flush pads the half frame
    start_run();
    c = 0;
    while (acc_n < N + N / 2 && c < 5000) begin
      vin = 1'($urandom);
      din = $urandom;
      rdy = 1'($urandom);
      step();
      c++;
    end
    vin = 1'b0;
    chk("t4_fed", 64'(acc_n), 64'(N + N / 2));
    flush_and_drain("t4", 2 * N, 1'b1);

    // Flush with nothing in flight returns to idle at once
    start_run();
    fl = 1'b1;
    vin = 1'b1;
    step();
    fl = 1'b0;
    vin = 1'b0;
    chk("t5_empty_flush_idle", o_busy, 0);
    chk("t5_empty_flush_reset", o_fft_reset, 1);

    // Spurious sync mid-frame sets the sticky error
    start_run();
    rdy = 1'b1;
    c = 0;
    while (out_n < 5 && c < 2000) begin
      vin = 1'b1;
      din = $urandom;
      step();
      c++;
    end
    chk("t6_reached_idx5", 64'(out_n), 5);
    rdy = 1'b0;
    vin = 1'b0;
    step();
    chk("t6_valid_held", o_valid, 1);
    force_sync = 1'b1;
    step();
    force_sync = 1'b0;
    err_exp = 1'b1;
    repeat (5) step();
    chk("t6_err_sticky", o_err, 1);

    // Reset mid-frame
    rdy = 1'b1;
    vin = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("t1_fft_reset", o_fft_reset, 1);
    chk("t1_valid", o_valid, 0);
    chk("t1_ready", o_ready, 0);
    chk("t1_busy", o_busy, 0);
    chk("t1_err", o_err, 0);
    rst_n = 1'b1;
    vin = 1'b0;
    exp_q.delete();
    part_q.delete();
    err_exp = 1'b0;
    @(negedge clk);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
